// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake, instruction-memory write port and status signals of the image loader
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, error
  );
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, core_rst, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader packing a little-endian byte stream into instruction-memory words, holding core_rst low until the image is complete (ports: clk, rst active-low sync, bus = imem_loader_if.slave; optional trailing XOR checksum under IMEM_LOADER_CHECKSUM_EN)
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, LAST, DONE, ERROR, CSUM} state_t;
  localparam state_t END_HDR  = CSUM;
  localparam state_t END_DATA = CSUM;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, LAST, DONE, ERROR} state_t;
  localparam state_t END_HDR  = DONE;
  // LAST covers the final write cycle so done rises only after the last word lands
  localparam state_t END_DATA = LAST;
`endif
  state_t      state_q, state_d;
  logic [15:0] cnt_q, word_cnt_q;
  logic [1:0]  idx_q;
  logic [23:0] buf_q;
  logic        byte_ready_q, mem_we_q, core_rst_q, busy_q, done_q, error_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        hs, go, word_end, last_word, in_csum;
  logic [15:0] n_hdr;
  assign hs        = bus.byte_valid & byte_ready_q;
  assign go        = bus.start & (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign n_hdr     = {bus.byte_data, cnt_q[7:0]};
  assign word_end  = hs & (state_q == DATA) & (idx_q == 2'd3);
  assign last_word = word_cnt_q == cnt_q - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  assign in_csum = state_d == CSUM;
`else
  assign in_csum = 1'b0;
`endif
  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: state_d = go ? HDR0 : state_q;
      HDR0: state_d = hs ? HDR1 : HDR0;
      HDR1: state_d = !hs ? HDR1 : n_hdr > 16'(DEPTH) ? ERROR : n_hdr == 16'd0 ? END_HDR : DATA;
      DATA: state_d = word_end && last_word ? END_DATA : DATA;
      LAST: state_d = DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: state_d = !hs ? CSUM : bus.byte_data == csum_q ? DONE : ERROR;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      word_cnt_q   <= '0;
      idx_q        <= '0;
      buf_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      core_rst_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_ready_q <= state_d inside {HDR0, HDR1, DATA} || in_csum;
      busy_q       <= state_d inside {HDR0, HDR1, DATA, LAST} || in_csum;
      done_q       <= state_d == DONE;
      core_rst_q   <= state_d == DONE;
      error_q      <= state_d == ERROR;
      mem_we_q     <= word_end;
      if (go) begin
        word_cnt_q <= '0;
        idx_q      <= '0;
      end
      if (hs && state_q == HDR0) cnt_q[7:0] <= bus.byte_data;
      if (hs && state_q == HDR1) cnt_q[15:8] <= bus.byte_data;
      if (hs && state_q == DATA) begin
        idx_q <= idx_q + 2'd1;
        buf_q <= {bus.byte_data, buf_q[23:8]};
      end
      if (word_end) begin
        mem_wdata_q <= {bus.byte_data, buf_q};
        mem_addr_q  <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
        word_cnt_q  <= word_cnt_q + 16'd1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (go) csum_q <= '0;
      else if (hs && state_q != CSUM) csum_q <= csum_q ^ bus.byte_data;
`endif
    end
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the core's 32-entry instruction memory; the fetch stage is the reader of that memory.
- Accepts a byte stream through a valid/ready handshake, packs the bytes little-endian into 32-bit words, and issues one word write per packed word on a single-cycle write port.
- Holds the core in reset (core_rst low) until the whole image is written, then releases it.

Parameters:
- DEPTH, 32: instruction memory depth in words. A header count above DEPTH is an error.
- BASE_ADDR, 32'h0: byte address of the first word written. Must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low (same polarity as the core PC reset).
- start  in  1  one-cycle pulse that begins a load. Acted on only in IDLE, DONE or ERROR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle. A handshake is byte_valid & byte_ready at a rising edge.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write, word-aligned; the memory indexes it with [31:2].
- mem_wdata  out  32  word to write.
- core_rst  out  1  active-low reset to the core. Low except in DONE.
- busy  out  1  high in HDR0, HDR1, DATA and CSUM.
- done  out  1  image fully loaded.
- error  out  1  load aborted.

Behaviour:
- Reset: all outputs are 0 while rst is low at a clock edge (core_rst=0, mem_we=0, mem_addr=0, mem_wdata=0, byte_ready=0, busy=0, done=0, error=0); state goes to IDLE and the internal counters clear. Reset mid-load abandons the load. Words already written stay in memory.
- All outputs are registered. byte_ready=1 exactly in HDR0, HDR1, DATA and CSUM.
- Stream format: count low byte, count high byte (16-bit word count N), then N words. Each word is sent as 4 bytes, least significant first.
- States and transitions:
  - IDLE: start goes to HDR0 and clears the word counter and byte index.
  - HDR0: on handshake, latch count[7:0], go to HDR1.
  - HDR1: on handshake, latch count[15:8]. If N > DEPTH, go to ERROR. If N == 0, go to CSUM if the macro is defined, else DONE. Otherwise go to DATA.
  - DATA: each handshake shifts the byte into the word at position byte_idx; byte_idx is 2 bits and wraps 3 to 0. On the 4th byte, the next cycle drives mem_we=1 for one cycle, with mem_wdata = the packed word and mem_addr = BASE_ADDR + 4*word_cnt. word_cnt then increments.
  - DATA exit: after word N's 4th handshake, go to CSUM if the macro is defined, else DONE.
  - Back-to-back bytes are accepted with no stall; the write port never blocks.
  - DONE: done=1 and core_rst=1, first asserted in the cycle after the final mem_we pulse, so the core never sees a partial image. Both hold until start or reset.
  - ERROR: error=1, core_rst=0, byte_ready=0. Holds until start or reset.
- Start from DONE or ERROR clears done/error, drives core_rst=0 on the next edge, and enters HDR0.
- start while busy is ignored.
- Gaps in byte_valid simply stall the FSM; there is no timeout.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers every handshaked byte, header included.
  - State CSUM accepts one trailing byte. If it equals the running XOR, go to DONE; otherwise go to ERROR.
  - Words already written are not rolled back.
- Undefined: no CSUM state, no checksum logic; DATA (or HDR1 when N=0) goes straight to DONE.

Test Plan:
- Two-word load, macro undefined: start; bytes 02 00 13 01 50 00 33 02 21 00, all back-to-back.
  -> mem_we @0x0 data 0x00500113, then mem_we @0x4 data 0x00210233.
  -> done=1 and core_rst=1 one cycle after the second write; byte_ready=0 in DONE.
- Same stream with byte_valid toggling every other cycle -> identical writes and final state; no byte lost or duplicated.
- Header 00 00 -> no mem_we; done=1 the cycle after the HDR1 handshake.
- Header 21 00 (N=33, DEPTH=32) -> error=1, core_rst=0, byte_ready=0, no writes. A subsequent start plus a valid stream completes normally.
- rst low for one edge after 5 data bytes of a 2-word load.
  -> all outputs at reset values, state IDLE.
  -> Restarting with the full stream writes both words and reaches done.
- Macro defined, one-word stream 01 00 13 01 50 00:
  - Checksum byte 0x43 -> done.
  - Checksum byte 0x44 -> error=1, core_rst=0; the word @0x0 was still written.
